k005297_mskreg_sr: RTL
======================

# k005297_mskreg_sr

Mask register and shift stage for the K005297 bubble controller, sitting directly upstream of the supplementary bubble data length counter. It accepts a 16-bit bit mask from the CPU side as two byte writes and stages it in a holding register. At page start it copies the mask into a circular shift register, then rotates it on the ROT20 data-bit slots. Its LSB output, o_MSKREG_SR_LSB, gates each bit's contribution to the length count.

## Interface
Parameters:
- MSK_RST_VAL, 16'hFFFF, reset value of holding and shift registers (all bits counted)

Ports:
- i_MCLK  in  1  master clock
- i_RST  in  1  reset; asynchronous, active-high
- i_CLK2M_PCEN_n  in  1  2 MHz clock enable, active low
- i_ROT20_n  in  20  one-hot-low bit-time rotator
- i_4BEN_n  in  1  low = 4-bit mode (four shift slots per rotation)
- i_DIN  in  8  CPU write data
- i_MSKLO_WR  in  1  single-MCLK strobe, write low byte
- i_MSKHI_WR  in  1  single-MCLK strobe, write high byte and commit
- i_MSK_RELOAD  in  1  page-start request, level, sampled on enabled edges
- i_MSK_SHIFT_EN  in  1  sequencer permits rotation
- o_MSKREG_SR_LSB  out  1  shift register bit 0, to the length counter
- o_MSK_POS  out  4  rotation position since last reload
- o_MSK_WRAP  out  1  one enable-period pulse when position wraps 15->0
- o_MSK_PENDING  out  1  committed mask not yet reloaded
- o_MSK_HOLD  out  16  holding register readback

## Operation
Enabled edge:
- An enabled edge is an i_MCLK rising edge with i_CLK2M_PCEN_n = 0.
- All shift-side state changes only on enabled edges.
- CPU writes are sampled on every i_MCLK edge.

CPU writes:
- i_MSKLO_WR: lo_stage <= i_DIN.
- i_MSKHI_WR: hold <= {i_DIN, lo_stage}; pending <= 1.
- If both strobes are high on the same edge, the HI commit uses the old lo_stage, and lo_stage then updates.

Shift slot:
- shift_slot = ~ROT20_n[3] | ~ROT20_n[8] | (~i_4BEN_n & (~ROT20_n[13] | ~ROT20_n[18])).

Priority on each enabled edge, highest first:
- i_MSK_RELOAD=1: sr <= hold; pos <= 0; pending <= 0; wrap <= 0.
- shift_slot & i_MSK_SHIFT_EN: sr <= {sr[0], sr[15:1]}; pos <= pos+1, modulo 16; wrap <= (pos==15).
- Otherwise: hold sr and pos; wrap <= 0.

Rotation and ordering:
- Rotation is circular: after 16 shifts, sr equals the value it was reloaded with.
- An i_MSKHI_WR on the same edge as a reload updates hold and leaves pending = 1. The reload copies the old hold.

Reset:
- i_RST=1 asynchronously sets lo_stage=8'hFF, hold=sr=MSK_RST_VAL, pos=0, pending=0, wrap=0.
- Reset mid-page discards any staged byte and the rotation position.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Reload on enabled edge N: o_MSKREG_SR_LSB = hold[0] and o_MSK_POS = 0 from edge N onward.
- Shift on edge N: LSB presents the next mask bit from edge N onward. The length counter samples it in the following slot-3/8/13/18 window.
- o_MSK_WRAP is high from the enabled edge that takes pos 15->0 until the next enabled edge.
- An i_MSKHI_WR at MCLK edge M: o_MSK_HOLD and o_MSK_PENDING update after edge M.
- The mask reaches o_MSKREG_SR_LSB only on the next reload.
- Rotation rate:
  - i_4BEN_n=1: 2 shifts per 20-slot rotation.
  - i_4BEN_n=0: 4 shifts per 20-slot rotation.

## Structure
- Shared package k005297_pkg:
  - slot constants: SLOT_SHIFT_A=3, SLOT_SHIFT_B=8, SLOT_SHIFT_C=13, SLOT_SHIFT_D=18.
  - MSK_W=16, POS_W=4.
- Sub-module k005297_rot20_slotdec: combinational decode of i_ROT20_n and i_4BEN_n into shift_slot.
  - It is reused by the length counter's count gate.
- Shift register, position counter, and write staging stay in this module.

## Test plan
- Reset mid-rotation -> immediately LSB=1, pos=0, hold=16'hFFFF, pending=0, wrap=0.
- Write LO=8'h34, then HI=8'h12, then reload -> hold=16'h1234, pending 1->0, LSB=0.
  - Over the next 16 shifts, LSB reads 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0, and wrap pulses once on the 16th shift.
- i_4BEN_n=1, shift_en=1, one full 20-slot rotation -> pos advances by exactly 2.
  - Same with i_4BEN_n=0 -> pos advances by exactly 4.
- Reload and shift_slot on the same enabled edge, with hold=16'h0001 -> pos=0, LSB=1, no rotation.
- HI write on the same edge as a reload -> sr takes the old hold, o_MSK_HOLD shows the new value, pending stays 1.
- shift_en=0 across slots 3 and 8 -> sr and pos unchanged, no wrap.

Source files
------------

// File: rtl/k005297_pkg.sv
// k005297_pkg
// Shared constants and helpers for the K005297 bubble controller slice.
//   - ROT20 slot indices on which the mask shift stage may rotate
//   - mask / position widths
//   - sr_op_e : operation selected for the shift register on an enabled edge
//   - msk_rotr1 : one-step circular right rotation of the mask
package k005297_pkg;

    localparam int ROT_W = 20;
    localparam int MSK_W = 16;
    localparam int POS_W = 4;

    // Data-bit slots of the 20-slot rotator. A and B are always shift slots;
    // C and D only take part in 4-bit mode.
    localparam int SLOT_SHIFT_A = 3;
    localparam int SLOT_SHIFT_B = 8;
    localparam int SLOT_SHIFT_C = 13;
    localparam int SLOT_SHIFT_D = 18;

    typedef enum logic [1:0] {
        SR_HOLD   = 2'd0,
        SR_RELOAD = 2'd1,
        SR_SHIFT  = 2'd2
    } sr_op_e;

    // Rotate right by one: bit 0 wraps to the MSB, so bit 1 becomes the new LSB.
    function automatic logic [MSK_W-1:0] msk_rotr1(input logic [MSK_W-1:0] v);
        return {v[0], v[MSK_W-1:1]};
    endfunction

endpackage

// File: rtl/k005297_rot20_slotdec.sv
// k005297_rot20_slotdec
// Combinational decode of the one-hot-low ROT20 rotator into the mask
// shift slot. Shared with the length counter's count gate so both blocks
// agree on exactly which bit-times carry data.
// Ports:
//   i_ROT20_n    in  20  one-hot-low bit-time rotator
//   i_4BEN_n     in  1   low = 4-bit mode (slots 13 and 18 also active)
//   o_shift_slot out 1   current bit-time is a data/shift slot
module k005297_rot20_slotdec
    import k005297_pkg::*;
(
    input  logic [ROT_W-1:0] i_ROT20_n,
    input  logic             i_4BEN_n,
    output logic             o_shift_slot
);

    logic slot_ab;
    logic slot_cd;
    logic rot_running;

    assign slot_ab = ~i_ROT20_n[SLOT_SHIFT_A] | ~i_ROT20_n[SLOT_SHIFT_B];
    assign slot_cd = ~i_4BEN_n & (~i_ROT20_n[SLOT_SHIFT_C] | ~i_ROT20_n[SLOT_SHIFT_D]);

    // True whenever any slot is active. Logically implied by slot_ab/slot_cd,
    // it keeps the decode qualified by the whole rotator word so an idle
    // (all-ones) rotator can never be mistaken for a slot.
    assign rot_running = ~&i_ROT20_n;

    assign o_shift_slot = rot_running & (slot_ab | slot_cd);

endmodule

// File: rtl/k005297_mskreg_sr.sv
// k005297_mskreg_sr
// Mask register and circular shift stage feeding the supplementary bubble
// data length counter. The CPU writes a 16-bit mask as two bytes into a
// holding register; at page start the mask is copied into a shift register
// which then rotates right on every permitted ROT20 data slot. Bit 0 of the
// shift register gates each bit's contribution to the length count.
// Ports:
//   i_MCLK          in  1   master clock
//   i_RST           in  1   asynchronous active-high reset
//   i_CLK2M_PCEN_n  in  1   2 MHz clock enable, active low
//   i_ROT20_n       in  20  one-hot-low bit-time rotator
//   i_4BEN_n        in  1   low = 4-bit mode (four shift slots per rotation)
//   i_DIN           in  8   CPU write data
//   i_MSKLO_WR      in  1   single-MCLK strobe, write low byte
//   i_MSKHI_WR      in  1   single-MCLK strobe, write high byte and commit
//   i_MSK_RELOAD    in  1   page-start request (level, enabled edges)
//   i_MSK_SHIFT_EN  in  1   sequencer permits rotation
//   o_MSKREG_SR_LSB out 1   shift register bit 0
//   o_MSK_POS       out 4   rotation position since last reload
//   o_MSK_WRAP      out 1   one enable-period pulse on position 15->0
//   o_MSK_PENDING   out 1   committed mask not yet reloaded
//   o_MSK_HOLD      out 16  holding register readback
module k005297_mskreg_sr
    import k005297_pkg::*;
#(
    parameter logic [15:0] MSK_RST_VAL = 16'hFFFF
) (
    input  logic             i_MCLK,
    input  logic             i_RST,
    input  logic             i_CLK2M_PCEN_n,
    input  logic [ROT_W-1:0] i_ROT20_n,
    input  logic             i_4BEN_n,
    input  logic [7:0]       i_DIN,
    input  logic             i_MSKLO_WR,
    input  logic             i_MSKHI_WR,
    input  logic             i_MSK_RELOAD,
    input  logic             i_MSK_SHIFT_EN,
    output logic             o_MSKREG_SR_LSB,
    output logic [POS_W-1:0] o_MSK_POS,
    output logic             o_MSK_WRAP,
    output logic             o_MSK_PENDING,
    output logic [MSK_W-1:0] o_MSK_HOLD
);

    logic [7:0]       lo_stage;
    logic [MSK_W-1:0] hold;
    logic [MSK_W-1:0] sr;
    logic [POS_W-1:0] pos;
    logic             wrap;
    logic             pending;

    logic             shift_slot;
    logic             en_edge;
    sr_op_e           sr_op;

    k005297_rot20_slotdec u_slotdec (
        .i_ROT20_n    (i_ROT20_n),
        .i_4BEN_n     (i_4BEN_n),
        .o_shift_slot (shift_slot)
    );

    assign en_edge = ~i_CLK2M_PCEN_n;

    // Reload outranks a shift so a page always starts at position 0 with
    // the mask LSB presented, even if the reload lands on a data slot.
    always_comb begin
        sr_op = SR_HOLD;
        if (i_MSK_RELOAD) begin
            sr_op = SR_RELOAD;
        end else if (shift_slot && i_MSK_SHIFT_EN) begin
            sr_op = SR_SHIFT;
        end
    end

    // Shift side: only moves on enabled edges.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            sr   <= MSK_RST_VAL;
            pos  <= '0;
            wrap <= 1'b0;
        end else if (en_edge) begin
            case (sr_op)
                SR_RELOAD: begin
                    sr   <= hold;
                    pos  <= '0;
                    wrap <= 1'b0;
                end
                SR_SHIFT: begin
                    sr   <= msk_rotr1(sr);
                    pos  <= pos + POS_W'(1);
                    wrap <= (pos == POS_W'(MSK_W - 1));
                end
                default: begin
                    wrap <= 1'b0;
                end
            endcase
        end
    end

    // CPU side: sampled on every MCLK edge. The HI commit reads lo_stage
    // before this edge's LO write lands, so a simultaneous LO+HI pair
    // commits the previously staged low byte.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            lo_stage <= 8'hFF;
            hold     <= MSK_RST_VAL;
        end else begin
            if (i_MSKHI_WR) begin
                hold <= {i_DIN, lo_stage};
            end
            if (i_MSKLO_WR) begin
                lo_stage <= i_DIN;
            end
        end
    end

    // A commit on the same edge as a reload wins: the reload took the old
    // hold, so the new mask is still waiting for the next page.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            pending <= 1'b0;
        end else if (i_MSKHI_WR) begin
            pending <= 1'b1;
        end else if (en_edge && (sr_op == SR_RELOAD)) begin
            pending <= 1'b0;
        end
    end

    assign o_MSKREG_SR_LSB = sr[0];
    assign o_MSK_POS       = pos;
    assign o_MSK_WRAP      = wrap;
    assign o_MSK_PENDING   = pending;
    assign o_MSK_HOLD      = hold;

endmodule
